// File: rtl/core_csr_regfile_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encodings,
// constant CSR values and small value-legalising helpers.
package core_csr_regfile_pkg;

  localparam int unsigned CSR_DW = 32;

  typedef enum logic [1:0] {
    CSR_OP_RW   = 2'b00,
    CSR_OP_RS   = 2'b01,
    CSR_OP_RC   = 2'b10,
    CSR_OP_RSVD = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [CSR_DW-1:0] CSR_MISA_VAL    = 32'h4000_0100;
  localparam logic [CSR_DW-1:0] MSTATUS_RST     = 32'h0000_1800;
  localparam logic [CSR_DW-1:0] MSTATUS_WR_MASK = 32'h0000_0088;
  localparam logic [CSR_DW-1:0] ALIGN4_MASK     = 32'hFFFF_FFFC;

  function automatic logic [CSR_DW-1:0] csr_alu(input csr_op_e op,
                                                input logic [CSR_DW-1:0] old_v,
                                                input logic [CSR_DW-1:0] wdat);
    logic [CSR_DW-1:0] res;
    case (op)
      CSR_OP_RW: res = wdat;
      CSR_OP_RS: res = old_v | wdat;
      CSR_OP_RC: res = old_v & ~wdat;
      default:   res = old_v;
    endcase
    return res;
  endfunction

  // Only MIE/MPIE are stored; MPP reads back as machine mode.
  function automatic logic [CSR_DW-1:0] mstatus_legal(input logic [CSR_DW-1:0] v);
    return (v & MSTATUS_WR_MASK) | MSTATUS_RST;
  endfunction

  function automatic logic [CSR_DW-1:0] mstatus_pack(input logic mie, input logic mpie);
    logic [CSR_DW-1:0] res;
    res    = MSTATUS_RST;
    res[3] = mie;
    res[7] = mpie;
    return res;
  endfunction

endpackage

// File: rtl/core_csr_regfile_counter64.sv
// 64-bit free-running counter with per-half overwrite; a write to either half
// takes precedence over the increment for that cycle.
module core_csr_counter64
  import core_csr_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_en_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [CSR_DW-1:0] wdat_i,
  output logic [63:0]       cnt_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // Next count: half writes replace the increment, otherwise count up with full carry.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) begin
        cnt_d[31:0] = wdat_i;
      end else begin
        cnt_d[31:0] = cnt_q[31:0];
      end
      if (wr_hi_i) begin
        cnt_d[63:32] = wdat_i;
      end else begin
        cnt_d[63:32] = cnt_q[63:32];
      end
    end else if (inc_en_i) begin
      cnt_d = cnt_q + 64'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/core_csr_regfile.sv
// Machine-mode CSR file: CSR instruction execution, trap-commit writes with
// MIE/MPIE stacking, mret unstacking, and the mcycle/minstret counters.
module core_csr_regfile
  import core_csr_regfile_pkg::*;
#(
  parameter int unsigned       XLEN        = 32,
  parameter logic [XLEN-1:0]   MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_ena,
  input  logic            csr_wr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] csr_wdat,
  output logic [XLEN-1:0] csr_rdat,
  output logic            csr_illegal,
  input  logic            cmt_mstatus_en,
  input  logic            cmt_mcause_en,
  input  logic            cmt_mepc_en,
  input  logic [XLEN-1:0] cmt_mstatus,
  input  logic [XLEN-1:0] cmt_mcause,
  input  logic [XLEN-1:0] cmt_mepc,
  input  logic            cmt_mret_ena,
  input  logic            cmt_instret,
  output logic [XLEN-1:0] csr_mtvec,
  output logic [XLEN-1:0] csr_mepc,
  output logic            csr_mie
);

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle_s, minstret_s;
  logic [XLEN-1:0] rd_val_s, new_val_s;
  logic            known_s, ena_s, illegal_s, csr_we_s;

  // Reset forces the read port quiet even if EX happens to hold a CSR op.
  assign ena_s = csr_ena & rst_n;

  // Old-value read mux and address decode.
  always_comb begin
    rd_val_s = '0;
    known_s  = 1'b1;
    case (csr_idx)
      CSR_MSTATUS:                 rd_val_s = mstatus_q;
      CSR_MISA:                    rd_val_s = CSR_MISA_VAL;
      CSR_MTVEC:                   rd_val_s = mtvec_q;
      CSR_MSCRATCH:                rd_val_s = mscratch_q;
      CSR_MEPC:                    rd_val_s = mepc_q;
      CSR_MCAUSE:                  rd_val_s = mcause_q;
      CSR_MCYCLE,   CSR_CYCLE:     rd_val_s = mcycle_s[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    rd_val_s = mcycle_s[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rd_val_s = minstret_s[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val_s = minstret_s[63:32];
      CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID,   CSR_MHARTID:   rd_val_s = '0;
      default: begin
        rd_val_s = '0;
        known_s  = 1'b0;
      end
    endcase
  end

  assign illegal_s = ena_s & (~known_s | (csr_op == CSR_OP_RSVD) |
                              (csr_wr_en & (csr_idx[11:10] == 2'b11)));
  assign csr_we_s  = ena_s & csr_wr_en & ~illegal_s;
  assign new_val_s = csr_alu(csr_op_e'(csr_op), rd_val_s, csr_wdat);

  // Next state: trap commit beats mret, which beats the CSR instruction write.
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (cmt_mstatus_en) begin
      mstatus_d = mstatus_legal(cmt_mstatus);
    end else if (cmt_mcause_en) begin
      mstatus_d = mstatus_pack(1'b0, mstatus_q[3]);
    end else if (cmt_mret_ena) begin
      mstatus_d = mstatus_pack(mstatus_q[7], 1'b1);
    end else if (csr_we_s && (csr_idx == CSR_MSTATUS)) begin
      mstatus_d = mstatus_legal(new_val_s);
    end else begin
      mstatus_d = mstatus_q;
    end

    if (cmt_mcause_en) begin
      mcause_d = cmt_mcause;
    end else if (csr_we_s && (csr_idx == CSR_MCAUSE)) begin
      mcause_d = new_val_s;
    end else begin
      mcause_d = mcause_q;
    end

    if (cmt_mepc_en) begin
      mepc_d = cmt_mepc & ALIGN4_MASK;
    end else if (csr_we_s && (csr_idx == CSR_MEPC)) begin
      mepc_d = new_val_s & ALIGN4_MASK;
    end else begin
      mepc_d = mepc_q;
    end

    if (csr_we_s && (csr_idx == CSR_MTVEC)) begin
      mtvec_d = new_val_s & ALIGN4_MASK;
    end else begin
      mtvec_d = mtvec_q;
    end

    if (csr_we_s && (csr_idx == CSR_MSCRATCH)) begin
      mscratch_d = new_val_s;
    end else begin
      mscratch_d = mscratch_q;
    end
  end

  // CSR state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_RST;
      mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  core_csr_counter64 u_mcycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_en_i (1'b1),
    .wr_lo_i  (csr_we_s && (csr_idx == CSR_MCYCLE)),
    .wr_hi_i  (csr_we_s && (csr_idx == CSR_MCYCLEH)),
    .wdat_i   (new_val_s),
    .cnt_o    (mcycle_s)
  );

  core_csr_counter64 u_minstret (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_en_i (cmt_instret),
    .wr_lo_i  (csr_we_s && (csr_idx == CSR_MINSTRET)),
    .wr_hi_i  (csr_we_s && (csr_idx == CSR_MINSTRETH)),
    .wdat_i   (new_val_s),
    .cnt_o    (minstret_s)
  );

  assign csr_rdat    = ena_s ? rd_val_s : '0;
  assign csr_illegal = illegal_s;
  assign csr_mtvec   = {mtvec_q[XLEN-1:2], 2'b00};
  assign csr_mepc    = mepc_q;
  assign csr_mie     = mstatus_q[3];

endmodule

// File: tb/tb_core_csr_regfile.sv
// Directed and randomized checks of core_csr_regfile against an
// architectural CSR model held in plain bench variables.
module tb_core_csr_regfile;

  localparam logic [31:0] MTVEC_RST = 32'h8000_0100;

  logic        clk, rst_n;
  logic        csr_ena, csr_wr_en, csr_illegal;
  logic [1:0]  csr_op;
  logic [11:0] csr_idx;
  logic [31:0] csr_wdat, csr_rdat;
  logic        cmt_mstatus_en, cmt_mcause_en, cmt_mepc_en;
  logic [31:0] cmt_mstatus, cmt_mcause, cmt_mepc;
  logic        cmt_mret_ena, cmt_instret;
  logic [31:0] csr_mtvec, csr_mepc;
  logic        csr_mie;

  core_csr_regfile #(.XLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_ena(csr_ena), .csr_wr_en(csr_wr_en), .csr_op(csr_op),
    .csr_idx(csr_idx), .csr_wdat(csr_wdat), .csr_rdat(csr_rdat),
    .csr_illegal(csr_illegal),
    .cmt_mstatus_en(cmt_mstatus_en), .cmt_mcause_en(cmt_mcause_en),
    .cmt_mepc_en(cmt_mepc_en), .cmt_mstatus(cmt_mstatus),
    .cmt_mcause(cmt_mcause), .cmt_mepc(cmt_mepc),
    .cmt_mret_ena(cmt_mret_ena), .cmt_instret(cmt_instret),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mie(csr_mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  bit        m_mie, m_mpie;
  bit [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  bit [63:0] m_mcyc, m_minst;

  logic [31:0] last_rdat;
  logic        last_ill;

  logic [11:0] addr_tab [0:19] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF11,
                                   12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h344};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void mdl_read(input logic [11:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    case (a)
      12'h300: v = 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: v = 32'h4000_0100;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hB00, 12'hC00: v = m_mcyc[31:0];
      12'hB80, 12'hC80: v = m_mcyc[63:32];
      12'hB02, 12'hC02: v = m_minst[31:0];
      12'hB82, 12'hC82: v = m_minst[63:32];
      12'hF11, 12'hF12, 12'hF13, 12'hF14: v = 32'h0;
      default: begin v = 32'h0; known = 1'b0; end
    endcase
  endfunction

  function automatic bit mdl_illegal();
    logic [31:0] v;
    bit known;
    mdl_read(csr_idx, v, known);
    return csr_ena && (!known || csr_op == 2'b11 || (csr_wr_en && csr_idx[11:10] == 2'b11));
  endfunction

  function automatic void mdl_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mtvec = MTVEC_RST & 32'hFFFF_FFFC;
    m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
    m_mcyc = 64'h0; m_minst = 64'h0;
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  function automatic void mdl_tick();
    logic [31:0] old_v, nv;
    bit known, wr;
    mdl_read(csr_idx, old_v, known);
    wr = csr_ena && csr_wr_en && !mdl_illegal();
    case (csr_op)
      2'b00:   nv = csr_wdat;
      2'b01:   nv = old_v | csr_wdat;
      2'b10:   nv = old_v & ~csr_wdat;
      default: nv = old_v;
    endcase
    if (cmt_mstatus_en) begin
      m_mie = cmt_mstatus[3]; m_mpie = cmt_mstatus[7];
    end else if (cmt_mcause_en) begin
      m_mpie = m_mie; m_mie = 1'b0;
    end else if (cmt_mret_ena) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (wr && csr_idx == 12'h300) begin
      m_mie = nv[3]; m_mpie = nv[7];
    end
    if (cmt_mcause_en) m_mcause = cmt_mcause;
    else if (wr && csr_idx == 12'h342) m_mcause = nv;
    if (cmt_mepc_en) m_mepc = cmt_mepc & 32'hFFFF_FFFC;
    else if (wr && csr_idx == 12'h341) m_mepc = nv & 32'hFFFF_FFFC;
    if (wr && csr_idx == 12'h305) m_mtvec = nv & 32'hFFFF_FFFC;
    if (wr && csr_idx == 12'h340) m_mscratch = nv;
    if (wr && csr_idx == 12'hB00) m_mcyc[31:0] = nv;
    else if (wr && csr_idx == 12'hB80) m_mcyc[63:32] = nv;
    else m_mcyc = m_mcyc + 64'd1;
    if (wr && csr_idx == 12'hB02) m_minst[31:0] = nv;
    else if (wr && csr_idx == 12'hB82) m_minst[63:32] = nv;
    else if (cmt_instret) m_minst = m_minst + 64'd1;
  endfunction

  task automatic clear_inputs();
    csr_ena = 1'b0; csr_wr_en = 1'b0; csr_op = 2'b00; csr_idx = 12'h000; csr_wdat = 32'h0;
    cmt_mstatus_en = 1'b0; cmt_mcause_en = 1'b0; cmt_mepc_en = 1'b0;
    cmt_mstatus = 32'h0; cmt_mcause = 32'h0; cmt_mepc = 32'h0;
    cmt_mret_ena = 1'b0; cmt_instret = 1'b0;
  endtask

  // Check combinational outputs for the driven inputs, then clock once.
  task automatic cycle_run();
    logic [31:0] v;
    bit known;
    #1;
    mdl_read(csr_idx, v, known);
    check_eq("rdat", csr_rdat, csr_ena ? v : 32'h0);
    check_eq("illegal", {31'h0, csr_illegal}, {31'h0, mdl_illegal()});
    check_eq("mtvec", csr_mtvec, m_mtvec);
    check_eq("mepc", csr_mepc, m_mepc);
    check_eq("mie", {31'h0, csr_mie}, {31'h0, m_mie});
    last_rdat = csr_rdat;
    last_ill  = csr_illegal;
    @(posedge clk);
    mdl_tick();
    @(negedge clk);
  endtask

  task automatic csr_cyc(input logic [1:0] op, input logic [11:0] idx,
                         input logic [31:0] wdat, input logic wr_en);
    csr_ena = 1'b1; csr_op = op; csr_idx = idx; csr_wdat = wdat; csr_wr_en = wr_en;
    cycle_run();
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mie", {31'h0, csr_mie}, 32'h0);
    check_eq("rst_mtvec", csr_mtvec, MTVEC_RST & 32'hFFFF_FFFC);
    check_eq("rst_mepc", csr_mepc, 32'h0);
    check_eq("rst_rdat", csr_rdat, 32'h0);
    check_eq("rst_illegal", {31'h0, csr_illegal}, 32'h0);
    mdl_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    last_rdat = 32'h0;
    last_ill  = 1'b0;
    @(negedge clk);
    do_reset();

    csr_cyc(2'b01, 12'h300, 32'h0, 1'b0);
    check_eq("rst_mstatus", last_rdat, 32'h0000_1800);
    csr_cyc(2'b01, 12'h305, 32'h0, 1'b0);
    check_eq("rst_mtvec_rd", last_rdat, MTVEC_RST);

    csr_cyc(2'b00, 12'h340, 32'hDEAD_BEEF, 1'b1);
    check_eq("rw_old", last_rdat, 32'h0);
    csr_cyc(2'b01, 12'h340, 32'h0, 1'b0);
    check_eq("scratch", last_rdat, 32'hDEAD_BEEF);
    csr_cyc(2'b10, 12'h340, 32'h0000_00FF, 1'b1);
    csr_cyc(2'b01, 12'h340, 32'h0, 1'b0);
    check_eq("scratch_rc", last_rdat, 32'hDEAD_BE00);

    csr_cyc(2'b01, 12'h300, 32'h8, 1'b1);
    check_eq("mie_set", {31'h0, csr_mie}, 32'h1);
    cmt_mcause_en = 1'b1; cmt_mcause = 32'd11;
    cmt_mepc_en = 1'b1; cmt_mepc = 32'h8000_0104;
    cycle_run();
    clear_inputs();
    csr_cyc(2'b01, 12'h342, 32'h0, 1'b0);
    check_eq("ecall_mcause", last_rdat, 32'd11);
    csr_cyc(2'b01, 12'h341, 32'h0, 1'b0);
    check_eq("ecall_mepc", last_rdat, 32'h8000_0104);
    csr_cyc(2'b01, 12'h300, 32'h0, 1'b0);
    check_eq("ecall_mstatus", last_rdat, 32'h0000_1880);
    cmt_mret_ena = 1'b1;
    cycle_run();
    clear_inputs();
    csr_cyc(2'b01, 12'h300, 32'h0, 1'b0);
    check_eq("mret_mstatus", last_rdat, 32'h0000_1888);

    csr_ena = 1'b1; csr_op = 2'b00; csr_idx = 12'h342; csr_wdat = 32'd5; csr_wr_en = 1'b1;
    cmt_mcause_en = 1'b1; cmt_mcause = 32'd11;
    cycle_run();
    clear_inputs();
    csr_cyc(2'b01, 12'h342, 32'h0, 1'b0);
    check_eq("prio_mcause", last_rdat, 32'd11);

    csr_cyc(2'b00, 12'hB80, 32'h0, 1'b1);
    csr_cyc(2'b00, 12'hB00, 32'hFFFF_FFFF, 1'b1);
    csr_cyc(2'b01, 12'hB80, 32'h0, 1'b0);
    check_eq("mcycleh_pre", last_rdat, 32'h0);
    csr_cyc(2'b01, 12'hB00, 32'h0, 1'b0);
    check_eq("mcycle_wrap", last_rdat, 32'h0);
    csr_cyc(2'b01, 12'hB80, 32'h0, 1'b0);
    check_eq("mcycleh_carry", last_rdat, 32'h1);

    csr_cyc(2'b00, 12'hB02, 32'h0, 1'b1);
    csr_cyc(2'b00, 12'hB82, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cmt_instret = 1'b1;
      cycle_run();
      clear_inputs();
      cycle_run();
    end
    csr_cyc(2'b01, 12'hB02, 32'h0, 1'b0);
    check_eq("minstret3", last_rdat, 32'd3);

    csr_cyc(2'b00, 12'hC00, 32'h1234, 1'b1);
    check_eq("ill_c00", {31'h0, last_ill}, 32'h1);
    csr_cyc(2'b01, 12'h7C0, 32'h0, 1'b0);
    check_eq("ill_7c0", {31'h0, last_ill}, 32'h1);
    csr_cyc(2'b01, 12'hC00, 32'h0, 1'b0);
    check_eq("legal_c00", {31'h0, last_ill}, 32'h0);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      csr_ena   = ($urandom_range(0, 3) != 0);
      csr_wr_en = $urandom_range(0, 1);
      csr_op    = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      csr_idx   = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 19)];
      csr_wdat  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      cmt_mstatus_en = ($urandom_range(0, 7) == 0);
      cmt_mcause_en  = ($urandom_range(0, 7) == 0);
      cmt_mepc_en    = ($urandom_range(0, 7) == 0);
      cmt_mstatus    = 32'($urandom);
      cmt_mcause     = 32'($urandom);
      cmt_mepc       = 32'($urandom);
      cmt_mret_ena   = ($urandom_range(0, 5) == 0);
      cmt_instret    = $urandom_range(0, 1);
      cycle_run();
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
